// File: rtl/a2bus_stream_fifo.sv
// Apple II bus-capture streamer: filters bus cycles into 32-bit records, buffers them in a FIFO and
// serialises them MSB-first over a pclk/sync/data link, with in-band overflow markers for lost captures.
`timescale 1ns/1ps
module a2bus_stream_fifo #(
  parameter logic ENABLE      = 1'b1,
  parameter int   FIFO_DEPTH  = 16,
  parameter int   LANES       = 4,
  parameter int   NUM_WINDOWS = 2
) (
  input  logic                          clk_logic,
  input  logic                          system_reset_n,
  input  logic                          bus_strobe,
  input  logic [15:0]                   addr,
  input  logic [7:0]                    data,
  input  logic                          rw_n,
  input  logic                          m2sel_n,
  input  logic                          m2b0,
  input  logic                          sw_gs,
  input  logic                          capture_enable,
  input  logic [2:0]                    capture_mode,
  input  logic [NUM_WINDOWS-1:0]        win_en,
  input  logic [16*NUM_WINDOWS-1:0]     win_lo,
  input  logic [16*NUM_WINDOWS-1:0]     win_hi,
  input  logic                          heartbeat_pulse,
  output logic                          cam_pclk,
  output logic                          cam_sync,
  output logic [LANES-1:0]              cam_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_total,
  output logic                          activity_led,
  output logic                          overflow_led
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BEATS = 32 / LANES;
  localparam int BW    = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_GAP} ser_state_t;

  ser_state_t        state;
  logic [BW-1:0]     beat_cnt;
  logic [31:0]       shreg;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              start_pending, drop_pending, hb_pending, trigger_d;
  logic [15:0]       since_cnt;
  logic [7:0]        hb_cnt;

  logic mode_ok, win_ok, win_hit, trigger;
  logic full, empty, pop, can_push;
  logic start_push, marker_push, bus_push, bus_drop, hb_push, push;
  logic [15:0] marker_cnt;
  logic [31:0] push_data, head;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    mode_ok = 1'b0;
    case (capture_mode)
      3'b000: mode_ok = 1'b1;
      3'b001: mode_ok = (addr[15:12] == 4'hC);
      3'b010: mode_ok = (addr[15:9] == 7'd0);
      3'b011: mode_ok = (addr >= 16'h0400 && addr <= 16'h07FF) || (addr >= 16'h2000 && addr <= 16'h3FFF);
      3'b100: mode_ok = (addr >= 16'hD000);
      3'b101: mode_ok = !rw_n;
      3'b110: mode_ok = rw_n;
      default: mode_ok = (addr >= 16'hC000 && addr <= 16'hC03F);
    endcase
  end

  always_comb begin
    win_hit = 1'b0;
    for (int i = 0; i < NUM_WINDOWS; i++) begin
      if (win_en[i] && win_lo[16*i +: 16] <= addr && addr <= win_hi[16*i +: 16]) win_hit = 1'b1;
    end
    win_ok = (win_en == '0) || win_hit;
  end

  assign trigger  = ENABLE & capture_enable & bus_strobe & !m2sel_n & mode_ok & win_ok;
  assign full     = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign empty    = (fifo_level == '0);
  assign pop      = (state == S_IDLE || state == S_GAP) && !empty;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept a push.
  assign can_push = !full || pop;
  assign head     = mem[rd_ptr];

  always_comb begin
    start_push  = start_pending & can_push;
    marker_push = !start_push & drop_pending & can_push;
    bus_push    = !start_push & trigger & can_push & !drop_pending;
    bus_drop    = trigger & !bus_push;
    hb_push     = ENABLE & hb_pending & can_push & !start_push & !marker_push & !bus_push;
    push        = start_push | marker_push | bus_push | hb_push;
    marker_cnt  = bus_drop ? sat_inc(since_cnt) : since_cnt;
    push_data   = {16'hC0FF, hb_cnt, 4'b0000, 3'b010, 1'b0};
    if (start_push)       push_data = {16'h0000, 8'h00, 8'h02};
    else if (marker_push) push_data = {marker_cnt, 8'h00, 4'b0000, 3'b011, 1'b0};
    else if (bus_push)    push_data = {addr, data, rw_n, m2sel_n, m2b0, sw_gs, 3'b000, 1'b0};
  end

  always_ff @(posedge clk_logic) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      start_pending <= 1'b1;
      drop_pending  <= 1'b0;
      hb_pending    <= 1'b0;
      since_cnt     <= '0;
      drop_total    <= '0;
      hb_cnt        <= '0;
      trigger_d     <= 1'b0;
    end else begin
      trigger_d <= trigger;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (start_push) start_pending <= 1'b0;
      if (bus_drop) drop_total <= sat_inc(drop_total);
      if (marker_push) begin
        drop_pending <= 1'b0;
        since_cnt    <= '0;
      end else if (bus_drop) begin
        drop_pending <= 1'b1;
        since_cnt    <= sat_inc(since_cnt);
      end
      if (hb_push) begin
        hb_pending <= 1'b0;
        hb_cnt     <= hb_cnt + 8'd1;
      end else if (heartbeat_pulse) begin
        hb_pending <= 1'b1;
      end
    end
  end

  // The gap clock also accepts a new packet, so consecutive packets are separated by one idle clock.
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      shreg    <= '0;
      cam_pclk <= 1'b0;
      cam_sync <= 1'b0;
      cam_data <= '0;
    end else begin
      case (state)
        S_LO: begin
          cam_pclk <= 1'b1;
          state    <= S_HI;
        end
        S_HI: begin
          cam_pclk <= 1'b0;
          if (beat_cnt == BW'(BEATS-1)) begin
            cam_sync <= 1'b0;
            cam_data <= '0;
            state    <= S_GAP;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            cam_data <= shreg[31 -: LANES];
            shreg    <= shreg << LANES;
            state    <= S_LO;
          end
        end
        default: begin
          cam_pclk <= 1'b0;
          if (pop) begin
            beat_cnt <= '0;
            cam_sync <= 1'b1;
            cam_data <= head[31 -: LANES];
            shreg    <= head << LANES;
            state    <= S_LO;
          end else begin
            cam_sync <= 1'b0;
            cam_data <= '0;
            state    <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign activity_led = trigger_d | (state != S_IDLE);
  assign overflow_led = drop_pending;

endmodule

// File: tb/tb_a2bus_stream_fifo.sv
// Directed bench for a2bus_stream_fifo: reassembles link packets from the beats and checks them
// against hand-computed records for start, bus, filter, window, overflow, heartbeat and reset cases.
`timescale 1ns/1ps
module tb_a2bus_stream_fifo;
  localparam int NW = 2;

  logic            clk_logic = 1'b0;
  logic            system_reset_n = 1'b0;
  logic            bus_strobe = 1'b0;
  logic [15:0]     addr = '0;
  logic [7:0]      data = '0;
  logic            rw_n = 1'b0, m2sel_n = 1'b0, m2b0 = 1'b0, sw_gs = 1'b0;
  logic            capture_enable = 1'b1;
  logic [2:0]      capture_mode = 3'b000;
  logic [NW-1:0]   win_en = '0;
  logic [16*NW-1:0] win_lo = '0, win_hi = '0;
  logic            heartbeat_pulse = 1'b0;
  logic            cam_pclk, cam_sync;
  logic [3:0]      cam_data;
  logic [2:0]      fifo_level;
  logic [15:0]     drop_total;
  logic            activity_led, overflow_led;

  int total = 0, bad = 0;
  logic [31:0] rx_q[$];
  int rx_rd = 0;
  int sync_cnt = 0;
  int mon_beats = 0;
  logic [31:0] mon_acc = '0;

  a2bus_stream_fifo #(.ENABLE(1'b1), .FIFO_DEPTH(4), .LANES(4), .NUM_WINDOWS(NW)) dut (
    .clk_logic(clk_logic), .system_reset_n(system_reset_n), .bus_strobe(bus_strobe),
    .addr(addr), .data(data), .rw_n(rw_n), .m2sel_n(m2sel_n), .m2b0(m2b0), .sw_gs(sw_gs),
    .capture_enable(capture_enable), .capture_mode(capture_mode), .win_en(win_en),
    .win_lo(win_lo), .win_hi(win_hi), .heartbeat_pulse(heartbeat_pulse),
    .cam_pclk(cam_pclk), .cam_sync(cam_sync), .cam_data(cam_data), .fifo_level(fifo_level),
    .drop_total(drop_total), .activity_led(activity_led), .overflow_led(overflow_led));

  always #5 clk_logic = ~clk_logic;

  // Link receiver: one nibble per pclk rising edge, eight nibbles per record.
  always @(posedge cam_pclk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      mon_beats = 0;
      mon_acc   = '0;
    end else begin
      mon_acc = {mon_acc[27:0], cam_data};
      mon_beats++;
      if (mon_beats == 8) begin
        rx_q.push_back(mon_acc);
        mon_beats = 0;
      end
    end
  end

  always @(negedge clk_logic) if (cam_sync) sync_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_logic);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic mb, input logic gs);
    addr = a; data = d; rw_n = rw; m2b0 = mb; sw_gs = gs;
    bus_strobe = 1'b1;
    tick(1);
    bus_strobe = 1'b0;
  endtask

  task automatic waitDrain();
    int quiet = 0;
    int cyc = 0;
    while (quiet < 4 && cyc < 3000) begin
      tick(1);
      cyc++;
      if (fifo_level == 0 && !activity_led) quiet++;
      else quiet = 0;
    end
    checkOutput("drain_quiet", quiet, 4);
  endtask

  task automatic checkPkt(input string tag, input logic [31:0] expected);
    logic [31:0] observed;
    observed = (rx_rd < rx_q.size()) ? rx_q[rx_rd] : 32'hxxxxxxxx;
    rx_rd++;
    checkOutput(tag, observed, expected);
  endtask

  initial begin
    $display("[TB] reset state");
    tick(3);
    checkOutput("rst_sync", cam_sync, 0);
    checkOutput("rst_pclk", cam_pclk, 0);
    checkOutput("rst_data", cam_data, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_drops", drop_total, 0);
    checkOutput("rst_act", activity_led, 0);
    checkOutput("rst_ovf", overflow_led, 0);

    $display("[TB] start packet after release");
    system_reset_n = 1'b1;
    tick(1);
    checkOutput("start_level", fifo_level, 1);
    tick(1);
    checkOutput("start_popped", fifo_level, 0);
    checkOutput("start_sync1", cam_sync, 1);
    checkOutput("start_pclk_lo", cam_pclk, 0);
    waitDrain();
    checkPkt("start_pkt", 32'h0000_0002);
    checkOutput("start_sync_clks", sync_cnt, 16);
    checkOutput("start_count", rx_q.size(), rx_rd);

    $display("[TB] bus records and flags");
    applyStimulus(16'hC030, 8'hA5, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h1234, 8'h5A, 1'b0, 1'b1, 1'b1);
    waitDrain();
    checkPkt("bus_c030", 32'hC030_A580);
    checkPkt("bus_flags", 32'h1234_5A30);

    $display("[TB] mode filters");
    capture_mode = 3'b001;
    applyStimulus(16'h1234, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'hC0FF, 8'h11, 1'b1, 1'b0, 1'b0);
    capture_mode = 3'b111;
    applyStimulus(16'hC040, 8'h22, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'hC03F, 8'h33, 1'b1, 1'b0, 1'b0);
    capture_mode = 3'b010;
    applyStimulus(16'h0200, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h01FE, 8'h44, 1'b1, 1'b0, 1'b0);
    capture_mode = 3'b101;
    applyStimulus(16'h5000, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h5001, 8'h55, 1'b0, 1'b0, 1'b0);
    capture_mode = 3'b000;
    waitDrain();
    checkPkt("mode_cxxx", 32'hC0FF_1180);
    checkPkt("mode_c03f", 32'hC03F_3380);
    checkPkt("mode_zp", 32'h01FE_4480);
    checkPkt("mode_wr", 32'h5001_5500);
    checkOutput("mode_count", rx_q.size(), rx_rd);

    $display("[TB] address windows");
    win_lo = {16'h8000, 16'h2000};
    win_hi = {16'h7000, 16'h3FFF};
    win_en = 2'b01;
    applyStimulus(16'h1FFF, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h2000, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h3FFF, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h4000, 8'h00, 1'b1, 1'b0, 1'b0);
    win_en = 2'b10;
    applyStimulus(16'h7800, 8'h00, 1'b1, 1'b0, 1'b0);
    win_en = 2'b00;
    waitDrain();
    checkPkt("win_2000", 32'h2000_0080);
    checkPkt("win_3fff", 32'h3FFF_0080);
    checkOutput("win_count", rx_q.size(), rx_rd);
    checkOutput("win_nodrops", drop_total, 0);

    $display("[TB] overflow with marker");
    system_reset_n = 1'b0;
    tick(2);
    system_reset_n = 1'b1;
    tick(1);
    rw_n = 1'b1; m2b0 = 1'b0; sw_gs = 1'b0;
    bus_strobe = 1'b1;
    for (int i = 0; i < 7; i++) begin
      addr = 16'h0100 + 16'(i);
      data = 8'(i);
      tick(1);
    end
    bus_strobe = 1'b0;
    checkOutput("ovf_level", fifo_level, 4);
    checkOutput("ovf_drops", drop_total, 3);
    checkOutput("ovf_led", overflow_led, 1);
    waitDrain();
    checkPkt("ovf_start", 32'h0000_0002);
    checkPkt("ovf_b0", 32'h0100_0080);
    checkPkt("ovf_b1", 32'h0101_0180);
    checkPkt("ovf_b2", 32'h0102_0280);
    checkPkt("ovf_b3", 32'h0103_0380);
    checkPkt("ovf_marker", 32'h0003_0006);
    checkOutput("ovf_count", rx_q.size(), rx_rd);
    checkOutput("ovf_drops_end", drop_total, 3);
    checkOutput("ovf_led_clr", overflow_led, 0);

    $display("[TB] heartbeat");
    heartbeat_pulse = 1'b1;
    applyStimulus(16'h0300, 8'h77, 1'b0, 1'b0, 1'b0);
    tick(1);
    heartbeat_pulse = 1'b0;
    waitDrain();
    checkPkt("hb_bus_first", 32'h0300_7700);
    checkPkt("hb_first", 32'hC0FF_0004);
    checkOutput("hb_count", rx_q.size(), rx_rd);
    heartbeat_pulse = 1'b1;
    tick(1);
    heartbeat_pulse = 1'b0;
    waitDrain();
    checkPkt("hb_second", 32'hC0FF_0104);

    $display("[TB] reset mid-packet");
    applyStimulus(16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    tick(5);
    checkOutput("mid_sync_before", cam_sync, 1);
    #2 system_reset_n = 1'b0;
    #1;
    checkOutput("mid_sync", cam_sync, 0);
    checkOutput("mid_pclk", cam_pclk, 0);
    checkOutput("mid_data", cam_data, 0);
    checkOutput("mid_level", fifo_level, 0);
    tick(2);
    system_reset_n = 1'b1;
    waitDrain();
    checkPkt("mid_restart", 32'h0000_0002);
    checkOutput("mid_count", rx_q.size(), rx_rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
